// File: rtl/srff_driver.sv
// srff_driver: plays a WIDTH-bit target pattern into an external SR flip-flop.
// Each bit is sent MSB first and takes two cycles. In DRIVE the registered
// set/reset excitation is applied. In CHECK the fed-back q is compared with
// the target bit. The block reports a done pulse, per-bit mismatch pulses and
// a saturating error count.
module srff_driver #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             q_in,
  output logic             s,
  output logic             r,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [4:0]       err_cnt
);

  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [IDX_W-1:0] idx;

  // SR excitation for target t given present q: {s, r}. Hold cases and the
  // don't-care entries both resolve to 0, so s and r are never both high.
  function automatic logic [1:0] excite(input logic t, input logic q);
    return {t & ~q, ~t & q};
  endfunction

  // Error counter increment that sticks at 31.
  function automatic logic [4:0] sat_inc(input logic [4:0] v);
    return (v == 5'd31) ? v : v + 5'd1;
  endfunction

  // Handshake and status are decoded directly from the state register.
  always_comb begin
    in_ready = (state == IDLE);
    busy     = (state != IDLE);
    done     = (state == DONE);
  end

  // Sequencer: accept a pattern, alternate DRIVE/CHECK per bit, then DONE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      shreg    <= '0;
      idx      <= '0;
      s        <= 1'b0;
      r        <= 1'b0;
      mismatch <= 1'b0;
      err_cnt  <= '0;
    end else begin
      s        <= 1'b0;
      r        <= 1'b0;
      mismatch <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg   <= in_data;
            idx     <= IDX_W'(WIDTH - 1);
            err_cnt <= '0;
            {s, r}  <= excite(in_data[WIDTH-1], q_in);
            state   <= DRIVE;
          end
        end
        DRIVE: begin
          state <= CHECK;
        end
        CHECK: begin
          if (q_in != shreg[WIDTH-1]) begin
            mismatch <= 1'b1;
            err_cnt  <= sat_inc(err_cnt);
          end
          if (idx != '0) begin
            idx    <= idx - IDX_W'(1);
            shreg  <= {shreg[WIDTH-2:0], 1'b0};
            {s, r} <= excite(shreg[WIDTH-2], q_in);
            state  <= DRIVE;
          end else begin
            state <= DONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_srff_driver.sv
// Directed bench for srff_driver: a behavioural SR flip-flop closes the loop
// (or q_in is tied low), and every expected value is a hand-computed constant.
module tb_srff_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       q_in;
  logic       s;
  logic       r;
  logic       busy;
  logic       done;
  logic       mismatch;
  logic [4:0] err_cnt;

  int checks = 0;
  int errors = 0;

  logic q_ff = 1'b0;
  logic tie0 = 1'b0;
  logic prev_done = 1'b0;

  srff_driver #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .q_in(q_in), .s(s), .r(r), .busy(busy), .done(done),
    .mismatch(mismatch), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // External SR flip-flop model: set wins over hold, reset clears.
  always @(posedge clk) begin
    if (s === 1'b1)      q_ff <= 1'b1;
    else if (r === 1'b1) q_ff <= 1'b0;
  end

  assign q_in = tie0 ? 1'b0 : q_ff;

  // Continuous properties: s/r exclusive, busy/in_ready exclusive, done one cycle wide.
  always @(negedge clk) begin
    checks = checks + 3;
    assert (!(s === 1'b1 && r === 1'b1)) else begin
      errors = errors + 1;
      $error("FAIL s_r_both s=%b r=%b required not both 1", s, r);
    end
    assert (!(busy === 1'b1 && in_ready === 1'b1)) else begin
      errors = errors + 1;
      $error("FAIL busy_ready busy=%b in_ready=%b required exclusive", busy, in_ready);
    end
    assert (!(prev_done === 1'b1 && done === 1'b1)) else begin
      errors = errors + 1;
      $error("FAIL done_width done high two cycles in a row");
    end
    prev_done = done;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks = checks + 1;
    assert (obs === exp_v) else begin
      errors = errors + 1;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one pattern from IDLE and follows it to completion.
  // es/er give the expected s/r in each DRIVE cycle, MSB first.
  task automatic run_pattern(input string tag, input logic [7:0] pat, input logic chk_sr,
                             input logic [7:0] es, input logic [7:0] er, input int exp_err);
    int mm;
    mm = 0;
    chk({tag, "_ready"}, in_ready, 1);
    in_valid = 1'b1;
    in_data  = pat;
    tick();
    // Offers while busy must be ignored.
    in_data = 8'h5A;
    for (int i = 7; i >= 0; i--) begin
      chk({tag, "_busy_drive"}, busy, 1);
      if (chk_sr) begin
        chk({tag, "_s"}, s, es[i]);
        chk({tag, "_r"}, r, er[i]);
      end
      tick();
      chk({tag, "_check_sr"}, {s, r}, 2'b00);
      chk({tag, "_done_early"}, done, 0);
      tick();
      if (mismatch === 1'b1) mm++;
    end
    in_valid = 1'b0;
    chk({tag, "_done_17"}, done, 1);
    chk({tag, "_mismatch_pulses"}, mm, exp_err);
    chk({tag, "_err_cnt"}, err_cnt, exp_err);
    tick();
    chk({tag, "_idle_ready"}, in_ready, 1);
    chk({tag, "_idle_done"}, done, 0);
    chk({tag, "_err_hold"}, err_cnt, exp_err);
  endtask

  function automatic logic [7:0] dval(input int k);
    return 8'((k * 53 + 29) % 256);
  endfunction

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Reset state
    tick();
    tick();
    chk("rst_s", s, 0);
    chk("rst_r", r, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mismatch", mismatch, 0);
    chk("rst_err", err_cnt, 0);
    rst = 1'b1;
    tick();
    chk("rst_exit_ready", in_ready, 1);

    // Reset beats a simultaneous transfer
    rst      = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    tick();
    chk("rst_prio_ready", in_ready, 1);
    chk("rst_prio_busy", busy, 0);
    chk("rst_prio_sr", {s, r}, 2'b00);
    rst      = 1'b1;
    in_valid = 1'b0;
    tick();
    chk("rst_prio_idle", busy, 0);

    // 1011_0010 from q=0: s,r,s,-,r,-,s,r
    run_pattern("p_b2", 8'b1011_0010, 1'b1, 8'b1010_0010, 8'b0100_1001, 0);
    chk("p_b2_q_final", q_ff, 0);

    // All zeros: no excitation at all
    run_pattern("p_00", 8'h00, 1'b1, 8'h00, 8'h00, 0);

    // q_in tied low, all ones: set every DRIVE, eight mismatches
    tie0 = 1'b1;
    run_pattern("p_ff", 8'hFF, 1'b1, 8'hFF, 8'h00, 8);
    tie0 = 1'b0;

    // Abort during the third CHECK (q_ff is 1 here)
    chk("abort_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = 8'h3C;
    tick();
    in_valid = 1'b0;
    chk("abort_first_r", {s, r}, 2'b01);
    repeat (5) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("abort_idle", in_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_sr", {s, r}, 2'b00);
    chk("abort_done", done, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abort_no_done", done, 0);
    end

    // A5 from q=1: -,r,s,r,-,s,r,s
    run_pattern("p_a5", 8'hA5, 1'b1, 8'b0010_0101, 8'b0101_0010, 0);

    // in_valid held with changing data: only IDLE-edge values are taken
    tie0     = 1'b1;
    in_valid = 1'b1;
    in_data  = dval(0);
    for (int k = 1; k <= 36; k++) begin
      tick();
      in_data = dval(k);
      chk("stream_done", done, (k == 17 || k == 35) ? 1 : 0);
      if (k == 1)  chk("stream_first_s", s, 0);
      if (k == 18) chk("stream_err_a", err_cnt, 4);
      if (k == 19) chk("stream_second_s", s, 1);
      if (k == 36) chk("stream_err_b", err_cnt, 6);
    end
    in_valid = 1'b0;
    tie0     = 1'b0;
    tick();
    chk("stream_idle", in_ready, 1);

    // Random patterns against the flip-flop model: no errors expected
    for (int n = 0; n < 4; n++) begin
      run_pattern("rand", 8'($urandom_range(0, 255)), 1'b0, 8'h00, 8'h00, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
